// File: rtl/tx_eth_arb.sv
// Two-source frame arbiter/sequencer ahead of the Ethernet TX framer: grants one source per frame,
// emits a one-cycle SOF strobe, passes payload to tlast, then holds off. Build macro: TX_ARB_STRICT_PRIO_EN.
module tx_eth_arb #(
    parameter int IFG_CYCLES = 20
) (
    input  logic        s_axis_aclk,
    input  logic        Reset,
    input  logic [47:0] src_mac,
    input  logic [47:0] s0_dst_mac,
    input  logic [15:0] s0_eth_type,
    input  logic [7:0]  s0_axis_tdata,
    input  logic        s0_axis_tvalid,
    input  logic        s0_axis_tlast,
    output logic        s0_axis_tready,
    input  logic [47:0] s1_dst_mac,
    input  logic [15:0] s1_eth_type,
    input  logic [7:0]  s1_axis_tdata,
    input  logic        s1_axis_tvalid,
    input  logic        s1_axis_tlast,
    output logic        s1_axis_tready,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac_o,
    output logic [15:0] eth_type,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_XFER, ST_GAP} state_t;

    state_t      r_state;
    logic [1:0]  r_grant;
    logic [7:0]  r_gap_cnt;
    logic [15:0] r_frame_cnt;
    logic [47:0] r_dst_mac;
    logic [47:0] r_src_mac;
    logic [15:0] r_eth_type;
    logic        r_tuser;
`ifndef TX_ARB_STRICT_PRIO_EN
    logic        r_last_s1;
`endif

    logic       w_xfer;
    logic       w_end;
    logic       w_pick1;
    logic [7:0] w_gap_load;

    assign w_gap_load = 8'(IFG_CYCLES - 1);
    assign w_xfer     = (r_state == ST_XFER);

    // Payload path is a pure mux so the framer sees source beats with no added latency.
    assign m_axis_tdata   = w_xfer ? (r_grant[1] ? s1_axis_tdata : s0_axis_tdata) : 8'h00;
    assign m_axis_tvalid  = w_xfer & (r_grant[1] ? s1_axis_tvalid : s0_axis_tvalid);
    assign m_axis_tlast   = w_xfer & (r_grant[1] ? s1_axis_tlast : s0_axis_tlast);
    assign s0_axis_tready = w_xfer & r_grant[0] & m_axis_tready;
    assign s1_axis_tready = w_xfer & r_grant[1] & m_axis_tready;
    assign w_end          = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    assign m_axis_tuser = r_tuser;
    assign grant        = r_grant;
    assign busy         = (r_state != ST_IDLE);
    assign frame_cnt    = r_frame_cnt;
    assign dst_mac      = r_dst_mac;
    assign src_mac_o    = r_src_mac;
    assign eth_type     = r_eth_type;

    always_comb begin
        w_pick1 = 1'b0;
        if (s0_axis_tvalid && s1_axis_tvalid) begin
`ifdef TX_ARB_STRICT_PRIO_EN
            w_pick1 = 1'b0;
`else
            w_pick1 = !r_last_s1;
`endif
        end else begin
            w_pick1 = s1_axis_tvalid;
        end
    end

    always_ff @(posedge s_axis_aclk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= 2'b00;
            r_gap_cnt   <= 8'h00;
            r_frame_cnt <= 16'h0000;
            r_dst_mac   <= 48'h0;
            r_src_mac   <= 48'h0;
            r_eth_type  <= 16'h0;
            r_tuser     <= 1'b0;
`ifndef TX_ARB_STRICT_PRIO_EN
            r_last_s1   <= 1'b1;
`endif
        end else begin
            r_tuser <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s0_axis_tvalid || s1_axis_tvalid) begin
                        r_state    <= ST_START;
                        r_tuser    <= 1'b1;
                        r_grant    <= w_pick1 ? 2'b10 : 2'b01;
                        r_dst_mac  <= w_pick1 ? s1_dst_mac : s0_dst_mac;
                        r_eth_type <= w_pick1 ? s1_eth_type : s0_eth_type;
                        r_src_mac  <= src_mac;
                    end
                end
                ST_START: r_state <= ST_XFER;
                ST_XFER: begin
                    if (w_end) begin
                        r_state     <= ST_GAP;
                        r_gap_cnt   <= w_gap_load;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
`ifndef TX_ARB_STRICT_PRIO_EN
                        r_last_s1   <= r_grant[1];
`endif
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 8'h00) begin
                        r_state <= ST_IDLE;
                        r_grant <= 2'b00;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_eth_arb.sv
// Directed bench for tx_eth_arb: queue-driven sources, negedge monitor, one task per scenario.
module tb_tx_eth_arb;

    logic        clk = 1'b0;
    logic        Reset;
    logic [47:0] src_mac;
    logic [47:0] s0_dst_mac, s1_dst_mac;
    logic [15:0] s0_eth_type, s1_eth_type;
    logic [7:0]  s0_axis_tdata, s1_axis_tdata;
    logic        s0_axis_tvalid, s1_axis_tvalid;
    logic        s0_axis_tlast, s1_axis_tlast;
    logic        s0_axis_tready, s1_axis_tready;
    logic [47:0] dst_mac, src_mac_o;
    logic [15:0] eth_type;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [47:0] MAC_S0  = 48'h02_00_00_00_00_A0;
    localparam logic [47:0] MAC_S1  = 48'h02_00_00_00_00_B1;
    localparam logic [47:0] MAC_SRC = 48'h0A_0B_0C_0D_0E_0F;

    always #5 clk = ~clk;

    tx_eth_arb #(.IFG_CYCLES(20)) dut (
        .s_axis_aclk(clk), .Reset(Reset), .src_mac(src_mac),
        .s0_dst_mac(s0_dst_mac), .s0_eth_type(s0_eth_type), .s0_axis_tdata(s0_axis_tdata),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
        .s1_dst_mac(s1_dst_mac), .s1_eth_type(s1_eth_type), .s1_axis_tdata(s1_axis_tdata),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
        .dst_mac(dst_mac), .src_mac_o(src_mac_o), .eth_type(eth_type),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .grant(grant), .busy(busy), .frame_cnt(frame_cnt)
    );

    // Source payload queues; the driver presents the head and pops it once accepted.
    logic [7:0] q0_d[$], q1_d[$];
    logic       q0_l[$], q1_l[$];
    logic       pop0 = 1'b0, pop1 = 1'b0;

    // Monitor records
    int          cyc = 0;
    int          first_req = -1;
    int          fall_cyc = -1;
    logic        prev_busy = 1'b0;
    int          tu_cyc[$];
    logic [1:0]  tu_g[$];
    logic [47:0] tu_dst[$], tu_src[$];
    logic [15:0] tu_et[$];
    logic [7:0]  bt_d[$];
    logic        bt_l[$];
    logic [1:0]  bt_g[$];
    logic [15:0] bt_et[$];
    int          bt_cyc[$];

    always @(negedge clk) begin
        cyc++;
        pop0 = s0_axis_tvalid & s0_axis_tready;
        pop1 = s1_axis_tvalid & s1_axis_tready;
        if (first_req < 0 && !busy && (s0_axis_tvalid || s1_axis_tvalid)) first_req = cyc;
        if (fall_cyc < 0 && prev_busy && !busy) fall_cyc = cyc;
        prev_busy = busy;
        if (m_axis_tuser) begin
            tu_cyc.push_back(cyc); tu_g.push_back(grant); tu_dst.push_back(dst_mac);
            tu_src.push_back(src_mac_o); tu_et.push_back(eth_type);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            bt_d.push_back(m_axis_tdata); bt_l.push_back(m_axis_tlast); bt_g.push_back(grant);
            bt_et.push_back(eth_type); bt_cyc.push_back(cyc);
        end
    end

    initial begin
        s0_axis_tvalid = 1'b0; s0_axis_tdata = 8'h00; s0_axis_tlast = 1'b0;
        s1_axis_tvalid = 1'b0; s1_axis_tdata = 8'h00; s1_axis_tlast = 1'b0;
        forever begin
            @(posedge clk);
            if (pop0 && q0_d.size() > 0) begin q0_d.delete(0); q0_l.delete(0); end
            if (pop1 && q1_d.size() > 0) begin q1_d.delete(0); q1_l.delete(0); end
            #1;
            s0_axis_tvalid = (q0_d.size() > 0);
            s0_axis_tdata  = (q0_d.size() > 0) ? q0_d[0] : 8'h00;
            s0_axis_tlast  = (q0_d.size() > 0) ? q0_l[0] : 1'b0;
            s1_axis_tvalid = (q1_d.size() > 0);
            s1_axis_tdata  = (q1_d.size() > 0) ? q1_d[0] : 8'h00;
            s1_axis_tlast  = (q1_d.size() > 0) ? q1_l[0] : 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_frame(input int src, input logic [7:0] first, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = first + 8'(i);
            if (src == 0) begin q0_d.push_back(b); q0_l.push_back(i == n - 1); end
            else          begin q1_d.push_back(b); q1_l.push_back(i == n - 1); end
        end
    endtask

    task automatic clear_rec();
        first_req = -1; fall_cyc = -1;
        tu_cyc.delete(); tu_g.delete(); tu_dst.delete(); tu_src.delete(); tu_et.delete();
        bt_d.delete(); bt_l.delete(); bt_g.delete(); bt_et.delete(); bt_cyc.delete();
    endtask

    task automatic wait_idle(input logic [15:0] target, input int bound);
        int n = 0;
        while (!(frame_cnt == target && busy == 1'b0) && n < bound) begin tick(); n++; end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL wait_idle: frame_cnt=%0d busy=%b, required frame_cnt=%0d and idle", frame_cnt, busy, target);
        end
        tick();
    endtask

    task automatic wait_beats(input int cnt, input int bound);
        int n = 0;
        while (bt_d.size() < cnt && n < bound) begin tick(); n++; end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL wait_beats: beats=%0d required %0d", bt_d.size(), cnt);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        checks++;
        if ({grant, busy, m_axis_tuser, m_axis_tvalid, m_axis_tlast, s0_axis_tready, s1_axis_tready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: grant=%b busy=%b tuser=%b tvalid=%b tlast=%b rdy0=%b rdy1=%b, required all 0",
                     grant, busy, m_axis_tuser, m_axis_tvalid, m_axis_tlast, s0_axis_tready, s1_axis_tready);
        end
        checks++;
        if ({dst_mac, src_mac_o, eth_type, frame_cnt, m_axis_tdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: dst=%h src=%h et=%h cnt=%h tdata=%h, required all 0",
                     dst_mac, src_mac_o, eth_type, frame_cnt, m_axis_tdata);
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] exp_d[4];
        exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_rec();
        q0_d.push_back(8'hAA); q0_l.push_back(1'b0);
        q0_d.push_back(8'hBB); q0_l.push_back(1'b0);
        q0_d.push_back(8'hCC); q0_l.push_back(1'b0);
        q0_d.push_back(8'hDD); q0_l.push_back(1'b1);
        wait_idle(16'd1, 200);
        checks++;
        if (tu_cyc.size() != 1 || tu_g[0] !== 2'b01) begin
            errors++;
            $display("FAIL single_tuser: pulses=%0d grant=%b, required 1 pulse with grant 01",
                     tu_cyc.size(), tu_g.size() > 0 ? tu_g[0] : 2'bxx);
        end else begin
            checks++;
            if (tu_dst[0] !== MAC_S0 || tu_et[0] !== 16'h0800 || tu_src[0] !== MAC_SRC) begin
                errors++;
                $display("FAIL single_hdr: dst=%h et=%h src=%h, required %h 0800 %h", tu_dst[0], tu_et[0], tu_src[0], MAC_S0, MAC_SRC);
            end
            checks++;
            if (tu_cyc[0] != first_req + 1) begin
                errors++;
                $display("FAIL single_latency: tuser at %0d, required %0d", tu_cyc[0], first_req + 1);
            end
        end
        checks++;
        if (bt_d.size() != 4) begin
            errors++;
            $display("FAIL single_beats: count=%0d required 4", bt_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (bt_d[i] !== exp_d[i] || bt_l[i] !== (i == 3) || bt_cyc[i] != tu_cyc[0] + 1 + i) begin
                    errors++;
                    $display("FAIL single_beat%0d: data=%h last=%b cyc=%0d, required %h %b %0d",
                             i, bt_d[i], bt_l[i], bt_cyc[i], exp_d[i], (i == 3), tu_cyc[0] + 1 + i);
                end
            end
            checks++;
            if (fall_cyc - bt_cyc[3] != 21) begin
                errors++;
                $display("FAIL single_gap: idle %0d cycles after tlast, required 21 (20 gap + return)", fall_cyc - bt_cyc[3]);
            end
        end
        checks++;
        if (frame_cnt !== 16'd1 || grant !== 2'b00) begin
            errors++;
            $display("FAIL single_end: frame_cnt=%0d grant=%b, required 1 and 00", frame_cnt, grant);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_d[12];
        logic [1:0] exp_g[4];
        exp_d = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h13, 8'h14, 8'h15, 8'h23, 8'h24, 8'h25};
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        Reset = 1'b1;
        tick();
        push_frame(0, 8'h10, 3); push_frame(0, 8'h13, 3);
        push_frame(1, 8'h20, 3); push_frame(1, 8'h23, 3);
        tick();
        clear_rec();
        Reset = 1'b0;
        wait_idle(16'd4, 500);
        checks++;
        if (tu_cyc.size() != 4) begin
            errors++;
            $display("FAIL cont_frames: tuser pulses=%0d required 4", tu_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (tu_g[i] !== exp_g[i] || tu_dst[i] !== (exp_g[i][1] ? MAC_S1 : MAC_S0) ||
                    tu_et[i] !== (exp_g[i][1] ? 16'h88B5 : 16'h0800)) begin
                    errors++;
                    $display("FAIL cont_grant%0d: grant=%b dst=%h et=%h, required grant %b", i, tu_g[i], tu_dst[i], tu_et[i], exp_g[i]);
                end
            end
        end
        checks++;
        if (bt_d.size() != 12) begin
            errors++;
            $display("FAIL cont_beats: count=%0d required 12", bt_d.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (bt_d[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL cont_beat%0d: data=%h required %h", i, bt_d[i], exp_d[i]);
                end
            end
        end
        checks++;
        if (frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL cont_cnt: frame_cnt=%0d required 4", frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        int n = 0, bad0 = 0, bad1 = 0, hi1 = 0, badg = 0;
        clear_rec();
        push_frame(1, 8'h30, 6);
        m_axis_tready = 1'b0;
        while (frame_cnt != 16'd5 && n < 300) begin
            tick(); n++;
            if (frame_cnt == 16'd5) break;
            m_axis_tready = ~m_axis_tready;
            #1;
            if (s0_axis_tready !== 1'b0) bad0++;
            if (m_axis_tvalid ? (s1_axis_tready !== m_axis_tready) : (s1_axis_tready !== 1'b0)) bad1++;
            if (s1_axis_tready === 1'b1) hi1++;
        end
        m_axis_tready = 1'b1;
        wait_idle(16'd5, 100);
        checks++;
        if (bad0 != 0) begin errors++; $display("FAIL bp_s0_ready: s0 tready high %0d cycles, required 0", bad0); end
        checks++;
        if (bad1 != 0 || hi1 != 6) begin
            errors++;
            $display("FAIL bp_s1_ready: mirror errors=%0d ready cycles=%0d, required 0 and 6", bad1, hi1);
        end
        checks++;
        if (bt_d.size() != 6 || tu_g.size() != 1) begin
            errors++;
            $display("FAIL bp_beats: beats=%0d tuser=%0d, required 6 and 1", bt_d.size(), tu_g.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (bt_d[i] !== 8'h30 + 8'(i) || bt_g[i] !== 2'b10 || bt_l[i] !== (i == 5)) badg++;
            end
            checks++;
            if (badg != 0 || tu_g[0] !== 2'b10) begin
                errors++;
                $display("FAIL bp_order: %0d bad beats, tuser grant=%b, required 0 and 10", badg, tu_g[0]);
            end
        end
    endtask

    task automatic test_header_stability();
        int bad = 0;
        clear_rec();
        push_frame(0, 8'h40, 6);
        wait_beats(3, 100);
        s0_eth_type = 16'h86DD;
        s0_dst_mac  = 48'h02_00_00_00_00_FF;
        src_mac     = 48'h0A_0B_0C_0D_0E_99;
        wait_beats(6, 100);
        #1;
        checks++;
        if (eth_type !== 16'h0800 || dst_mac !== MAC_S0 || src_mac_o !== MAC_SRC) begin
            errors++;
            $display("FAIL hdr_gap: et=%h dst=%h src=%h, required 0800 %h %h", eth_type, dst_mac, src_mac_o, MAC_S0, MAC_SRC);
        end
        wait_idle(16'd6, 100);
        for (int i = 0; i < bt_et.size(); i++) if (bt_et[i] !== 16'h0800) bad++;
        checks++;
        if (bad != 0 || bt_et.size() != 6) begin
            errors++;
            $display("FAIL hdr_stable: %0d beats with changed et out of %0d, required 0 of 6", bad, bt_et.size());
        end
        checks++;
        if (eth_type !== 16'h0800) begin
            errors++;
            $display("FAIL hdr_hold: et=%h required 0800 until next grant", eth_type);
        end
        push_frame(0, 8'h46, 2);
        wait_idle(16'd7, 100);
        checks++;
        if (tu_et.size() != 2 || tu_et[1] !== 16'h86DD || tu_dst[1] !== 48'h02_00_00_00_00_FF || tu_src[1] !== 48'h0A_0B_0C_0D_0E_99) begin
            errors++;
            $display("FAIL hdr_regrant: frames=%0d et=%h, required 2 with new header 86DD", tu_et.size(),
                     tu_et.size() > 1 ? tu_et[1] : 16'hxxxx);
        end
        s0_eth_type = 16'h0800; s0_dst_mac = MAC_S0; src_mac = MAC_SRC;
    endtask

    task automatic test_gap_single_beat();
        int l;
        clear_rec();
        push_frame(0, 8'h50, 2);
        wait_beats(2, 100);
        l = (bt_cyc.size() > 1) ? bt_cyc[1] : 0;
        tick(); tick(); tick();
        q1_d.push_back(8'h77); q1_l.push_back(1'b1);
        wait_idle(16'd9, 200);
        checks++;
        if (tu_cyc.size() != 2 || bt_d.size() != 3) begin
            errors++;
            $display("FAIL gap_frames: tuser=%0d beats=%0d, required 2 and 3", tu_cyc.size(), bt_d.size());
        end else begin
            checks++;
            if (tu_g[1] !== 2'b10 || tu_cyc[1] - l != 22) begin
                errors++;
                $display("FAIL gap_hold: s1 tuser %0d cycles after tlast grant=%b, required 22 and 10", tu_cyc[1] - l, tu_g[1]);
            end
            checks++;
            if (bt_d[2] !== 8'h77 || bt_l[2] !== 1'b1 || bt_cyc[2] != tu_cyc[1] + 1) begin
                errors++;
                $display("FAIL single_beat: data=%h last=%b cyc=%0d, required 77 1 %0d", bt_d[2], bt_l[2], bt_cyc[2], tu_cyc[1] + 1);
            end
        end
        checks++;
        if (frame_cnt !== 16'd9) begin
            errors++;
            $display("FAIL gap_cnt: frame_cnt=%0d required 9", frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_rec();
        push_frame(0, 8'h60, 8);
        wait_beats(2, 100);
        Reset = 1'b1;
        #1;
        checks++;
        if ({grant, busy, m_axis_tuser, m_axis_tvalid, m_axis_tlast, s0_axis_tready, s1_axis_tready} !== 7'b0 ||
            {dst_mac, src_mac_o, eth_type, frame_cnt, m_axis_tdata} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: grant=%b busy=%b tvalid=%b rdy0=%b tdata=%h cnt=%h et=%h, required all 0",
                     grant, busy, m_axis_tvalid, s0_axis_tready, m_axis_tdata, frame_cnt, eth_type);
        end
        tick();
        q0_d.delete(); q0_l.delete();
        tick();
        clear_rec();
        Reset = 1'b0;
        push_frame(1, 8'h70, 2);
        wait_idle(16'd1, 100);
        checks++;
        if (tu_cyc.size() != 1 || tu_g[0] !== 2'b10 || bt_d.size() != 2) begin
            errors++;
            $display("FAIL midrst_next: tuser=%0d beats=%0d, required 1 pulse grant 10 and 2 beats", tu_cyc.size(), bt_d.size());
        end else begin
            checks++;
            if (bt_d[0] !== 8'h70 || bt_d[1] !== 8'h71 || bt_cyc[0] != tu_cyc[0] + 1) begin
                errors++;
                $display("FAIL midrst_data: %h %h, required 70 71 right after tuser", bt_d[0], bt_d[1]);
            end
        end
    endtask

`ifdef TX_ARB_STRICT_PRIO_EN
    task automatic test_strict_prio();
        logic [1:0] exp_g[4];
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b10};
        Reset = 1'b1;
        tick();
        push_frame(0, 8'h80, 2); push_frame(0, 8'h82, 2); push_frame(0, 8'h84, 2);
        push_frame(1, 8'h90, 2);
        tick();
        clear_rec();
        Reset = 1'b0;
        wait_idle(16'd4, 500);
        checks++;
        if (tu_g.size() != 4) begin
            errors++;
            $display("FAIL strict_frames: tuser=%0d required 4", tu_g.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (tu_g[i] !== exp_g[i]) begin
                    errors++;
                    $display("FAIL strict_grant%0d: grant=%b required %b", i, tu_g[i], exp_g[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        Reset = 1'b1;
        m_axis_tready = 1'b1;
        src_mac = MAC_SRC;
        s0_dst_mac = MAC_S0; s0_eth_type = 16'h0800;
        s1_dst_mac = MAC_S1; s1_eth_type = 16'h88B5;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_header_stability();
        test_gap_single_beat();
        test_reset_mid_frame();
`ifdef TX_ARB_STRICT_PRIO_EN
        test_strict_prio();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_eth_arb.md
Name: tx_eth_arb

Overview:
Two-source frame arbiter and sequencer in front of the Ethernet TX framer. It picks one requesting byte-stream source per frame by round-robin and presents that source's header fields (dst MAC, EtherType) plus a shared src MAC. It emits the one-cycle start-of-frame tuser strobe the framer triggers on, then passes the payload through until tlast. After each frame it holds off for a fixed gap, which covers the framer's CRC tail and the inter-frame gap.

Parameters:
IFG_CYCLES, 20, idle cycles enforced after the last accepted payload beat before the next grant; legal range 1..255.

Ports:
s_axis_aclk  in  1  clock
Reset  in  1  asynchronous, active-high reset
src_mac  in  48  shared source MAC
s0_dst_mac  in  48  source 0 destination MAC, sampled at grant
s0_eth_type  in  16  source 0 EtherType, sampled at grant
s0_axis_tdata  in  8  source 0 payload
s0_axis_tvalid  in  1  source 0 valid; also acts as the frame request
s0_axis_tlast  in  1  source 0 last payload byte
s0_axis_tready  out  1  source 0 ready
s1_dst_mac, s1_eth_type, s1_axis_tdata, s1_axis_tvalid, s1_axis_tlast, s1_axis_tready  same as s0, for source 1
dst_mac  out  48  registered, held for the whole frame
src_mac_o  out  48  registered copy of src_mac, sampled at grant
eth_type  out  16  registered, held for the whole frame
m_axis_tdata  out  8  payload to framer
m_axis_tvalid  out  1  payload valid
m_axis_tlast  out  1  payload last
m_axis_tuser  out  1  start-of-frame strobe, exactly 1 cycle per frame
m_axis_tready  in  1  framer ready
grant  out  2  one-hot active source; 00 when none
busy  out  1  high in every state except IDLE
frame_cnt  out  16  completed frames, wraps at 0xFFFF to 0

Behaviour:
- States:
  - IDLE: no grant is active.
  - START: the start-of-frame strobe cycle.
  - XFER: payload pass-through.
  - GAP: post-frame hold-off.
- Reset values: all outputs 0, state IDLE, round-robin pointer set so source 0 wins the first tie, gap counter 0.
- IDLE:
  - A request is sN_axis_tvalid=1.
  - If exactly one source requests, grant it.
  - If both request, grant the source not granted last.
  - On grant (registered), latch dst_mac, src_mac_o and eth_type from the winner, set grant one-hot and go to START.
  - Latency from request sampled to START is 1 cycle.
- START: m_axis_tuser=1, m_axis_tvalid=0, both sN_axis_tready=0; go to XFER next cycle.
- XFER:
  - Combinational mux: m_axis_tdata, m_axis_tvalid and m_axis_tlast come from the granted source.
  - Granted sN_axis_tready = m_axis_tready; the non-granted tready stays 0.
  - Header outputs stay stable; a change on sN_dst_mac or sN_eth_type mid-frame has no effect.
  - A beat is accepted when tvalid & tready.
  - An accepted beat with tlast=1: go to GAP, load the gap counter with IFG_CYCLES-1, increment frame_cnt, update the round-robin pointer.
  - tvalid gaps from the source are passed through and do not end the frame.
- GAP:
  - m_axis_tvalid=0, all tready=0, grant held.
  - The counter decrements each cycle; at 0, go to IDLE and clear grant.
  - Requests arriving during GAP wait; they are evaluated in IDLE.
- A request that drops before grant is ignored; no state is kept for it.
- tlast with tvalid=0 or tready=0 is not a frame end.
- A single-beat frame (tlast on the first beat) is legal: START, one XFER beat, then GAP.
- Reset mid-frame: asynchronous return to IDLE; all outputs drop to 0 immediately and no tuser is generated. The partial frame is lost downstream, which is acceptable.
- frame_cnt counts only frames that completed with an accepted tlast.

Optional Feature:
TX_ARB_STRICT_PRIO_EN
- Defined: source 0 always wins when both request; the round-robin pointer is unused; a single requester is granted as normal.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Single source, no contention: s0 sends a 4-byte frame AA,BB,CC,DD (tlast on DD) with m_axis_tready=1 → grant=01; tuser pulses 1 cycle, then 4 m_axis_tvalid beats AA..DD with tlast on DD; then IFG_CYCLES=20 cycles of tvalid=0; frame_cnt=1.
- Contention: both sources valid from reset, each sending 3-byte frames, two frames each → grant order s0, s1, s0, s1; each frame's dst_mac and eth_type match its source; frame_cnt=4.
- Backpressure: m_axis_tready toggles 1,0,1,0 during a 6-byte s1 frame → each byte appears exactly once in order; s1_axis_tready mirrors m_axis_tready; s0_axis_tready stays 0.
- Header stability: s0_eth_type changes from 0x0800 to 0x86DD mid-frame → eth_type output stays 0x0800 until the next grant.
- Gap enforcement and single-beat frame: s1 requests 3 cycles after s0's tlast → s1's tuser occurs no earlier than 20 cycles after s0's tlast; a 1-byte frame completes with frame_cnt incremented.
- Reset mid-frame, plus TX_ARB_STRICT_PRIO_EN: assert Reset during XFER → all outputs 0 in the same cycle, and the next frame starts with a fresh tuser. With the macro defined and both sources continuously requesting, s0 is granted every frame.
